// File: rtl/iterative_mul_unit.sv
// iterative_mul_unit: radix-2 shift-add multiplier, one step per clock.
// Every operation takes exactly WIDTH busy cycles, with no early exit.
// Ports: Clock, Reset (async, active high), iStart/iSigned/iA/iB (request),
//        oReady (can accept), oDone (1-cycle pulse), oResult (2*WIDTH product).
// Macro IMUL_SIGNED_EN: when defined, iSigned selects two's-complement mode.
//        When undefined, iSigned is ignored and every operation is unsigned.
module iterative_mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic                 iSigned,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oReady,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_load;
    logic                  w_step;
    logic                  w_last;

    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [2*WIDTH-1:0]    r_result;

    logic [WIDTH-1:0]      w_mag_a;
    logic [WIDTH-1:0]      w_mag_b;
    logic [2*WIDTH-1:0]    w_add;
    logic [2*WIDTH-1:0]    w_acc_nxt;
    logic [2*WIDTH-1:0]    w_final;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        oReady      = 1'b1;
        oDone       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                oReady = 1'b0;
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                oDone = 1'b1;
                // Back-to-back start goes straight to BUSY, no idle bubble
                if (iStart) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_add     = r_mplier[0] ? r_mcand : '0;
    assign w_acc_nxt = r_acc + w_add;

`ifdef IMUL_SIGNED_EN
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic                  r_neg;

    assign w_neg_a = iSigned & iA[WIDTH-1];
    assign w_neg_b = iSigned & iB[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    assign w_mag_a = w_neg_a ? ({WIDTH{1'b0}} - iA) : iA;
    assign w_mag_b = w_neg_b ? ({WIDTH{1'b0}} - iB) : iB;
    assign w_final = r_neg ? ({2*WIDTH{1'b0}} - w_acc_nxt) : w_acc_nxt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_neg <= w_neg_a ^ w_neg_b;
        end
    end
`else
    logic                  w_unused_signed;

    assign w_unused_signed = iSigned;
    assign w_mag_a         = iA;
    assign w_mag_b         = iB;
    assign w_final         = w_acc_nxt;
`endif

    // Datapath: capture on load, one shift-add per busy cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
        end else begin
            if (w_load) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
            end else if (w_step) begin
                r_cnt    <= r_cnt + CW'(1);
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            // Result only moves on the final step, so it holds through BUSY
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign oResult = r_result;

endmodule

// File: doc/iterative_mul_unit.md
ITERATIVE_MUL_UNIT -- requirements
Module: iterative_mul_unit

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; legal range 4..32.
REQ-002 Port: Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: iStart  input  1  request to begin a multiply; sampled on rising edge of Clock.
REQ-005 Port: iSigned  input  1  1 = two's-complement operands, 0 = unsigned; sampled with iStart.
REQ-006 Port: iA  input  WIDTH  multiplicand; sampled with iStart.
REQ-007 Port: iB  input  WIDTH  multiplier; sampled with iStart.
REQ-008 Port: oReady  output  1  high when a new iStart will be accepted.
REQ-009 Port: oDone  output  1  single-cycle pulse marking oResult valid for a new product.
REQ-010 Port: oResult  output  2*WIDTH  product of last completed operation.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 oReady SHALL be 1 in IDLE and DONE and 0 in BUSY.
REQ-013 In IDLE or DONE, iStart=1 at a rising edge SHALL capture iA, iB, iSigned, clear the accumulator and iteration counter, and enter BUSY.
REQ-014 iStart while in BUSY SHALL be ignored; captured operands and progress are not disturbed.
REQ-015 BUSY SHALL perform one shift-add step per clock: if current multiplier LSB is 1, add the shifted multiplicand into a 2*WIDTH accumulator; shift the multiplier right one bit and the multiplicand left one bit.
REQ-016 The iteration counter SHALL count 0..WIDTH-1; on the edge where it equals WIDTH-1 the FSM SHALL enter DONE and load oResult with the final product.
REQ-017 No early termination: every operation SHALL take exactly WIDTH BUSY cycles regardless of operand values, including zero operands.
REQ-018 oDone SHALL be 1 for exactly the one cycle spent in DONE, i.e. WIDTH+1 rising edges after the edge that sampled iStart, counting the sampling edge as edge 0 and asserting in the cycle following edge WIDTH.
REQ-019 From DONE without iStart the FSM SHALL return to IDLE; with iStart it SHALL go directly to BUSY (back-to-back, no bubble).
REQ-020 oResult SHALL hold its value from the DONE load until the next DONE; it SHALL NOT change during BUSY.
REQ-021 Unsigned mode: oResult = iA * iB, exact, zero-extended to 2*WIDTH bits.
REQ-022 Signed mode: operands SHALL be converted to magnitudes at capture, multiplied unsigned, and the product negated in two's complement at DONE when operand signs differ; oResult is the exact 2*WIDTH signed product.
REQ-023 Most-negative operand (-2^(WIDTH-1)) SHALL be handled exactly; its magnitude fits WIDTH unsigned bits.
REQ-024 No overflow indication is required; 2*WIDTH bits always hold the exact product.

Reset
REQ-025 Reset=1 SHALL immediately, without Clock, force FSM to IDLE, counter and accumulator to 0, oResult to 0, oDone to 0, oReady to 1.
REQ-026 Reset asserted mid-BUSY SHALL abort the operation; no oDone is produced for it and oResult reads 0.
REQ-027 After Reset deasserts, the first iStart SHALL be accepted on the first rising edge with Reset low.

Configuration
REQ-028 Macro IMUL_SIGNED_EN SHALL control signed-mode support.
REQ-029 With IMUL_SIGNED_EN defined, iSigned SHALL select signed or unsigned operation per REQ-021/REQ-022.
REQ-030 Without IMUL_SIGNED_EN, iSigned SHALL remain a port but be ignored; all operations are unsigned per REQ-021, and magnitude/negation logic SHALL NOT be synthesised.

Verification
REQ-031 WIDTH=16, unsigned, iA=3, iB=5, iStart one cycle -> oReady low 16 cycles, oDone one-cycle pulse after edge 16, oResult=0x0000000F.
REQ-032 WIDTH=16, IMUL_SIGNED_EN, iSigned=1, iA=0xFFFD (-3), iB=5 -> oResult=0xFFFFFFF1; same stimulus without the macro -> oResult=0x0004FFF1.
REQ-033 WIDTH=16, signed, iA=iB=0x8000 -> oResult=0x40000000; unsigned iA=iB=0xFFFF -> oResult=0xFFFE0001.
REQ-034 Start 7*9, pulse iStart with 2*2 at BUSY cycle 5, then iStart held high through DONE with 4*6 -> first oDone gives 0x3F, second operation starts with no idle cycle and yields 0x18; the 2*2 request produces no result.
REQ-035 Start 100*100, assert Reset asynchronously between clock edges at BUSY cycle 8 -> oResult=0, oDone=0, oReady=1 immediately; no oDone follows; next 2*3 after release -> 0x6 at normal latency.
REQ-036 WIDTH=8 instance, unsigned 0xFF*0xFF -> oResult=0xFE01, oDone after edge 8.
